// File: rtl/eth_udp_rx.sv
// UDP receive extractor behind a GMII MAC: parses IPv4/UDP headers, buffers payload
// speculatively, commits on good CRC and streams datagrams out. Optional counters: ETH_UDP_RX_STATS_EN.
module eth_udp_rx #(
  parameter int          AW      = 11,
  parameter int          MW      = 2,
  parameter logic [15:0] UDPPORT = 16'd50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] myip,
  input  logic [7:0]  rx_data,
  input  logic        rx_dven,
  input  logic        rx_newframehead,
  input  logic [15:0] rx_ethertype,
  input  logic        rx_frameend,
  input  logic        rx_err,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [31:0] out_srcip,
  output logic [15:0] out_srcport,
  output logic [15:0] out_len,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_drop
);
  typedef enum logic [2:0] {P_IDLE, P_IP, P_UDP, P_PAY, P_WAIT, P_DROP} p_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} r_state_t;

  localparam int          DEPTH      = 1 << AW;
  localparam int          MDEPTH     = 1 << MW;
  localparam logic [16:0] MAX_UDPLEN = 17'(DEPTH + 7);
  localparam logic [AW:0] PONE       = 1;
  localparam logic [MW:0] MONE       = 1;

  p_state_t    p_state_q, p_state_d;
  r_state_t    r_state_q, r_state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] srcip_q, srcip_d;
  logic [15:0] srcport_q, srcport_d, udplen_q, udplen_d, pay_rem_q, pay_rem_d;
  logic [AW:0] wp_q, wp_d, wp_start_q, wp_start_d, wc_q, wc_d, rp_q, rp_d;
  logic [MW:0] meta_wp_q, meta_wp_d, meta_rp_q, meta_rp_d;
  logic [15:0] r_rem_q, r_rem_d;
  logic [31:0] out_srcip_q, out_srcip_d;
  logic [15:0] out_srcport_q, out_srcport_d, out_len_q, out_len_d;
  logic [15:0] udplen_full;
  logic        ip_bad, udp_bad, wr_en, rd_en, commit, discard, meta_pop;
  logic        buf_full, meta_full, meta_empty;
  logic [AW-1:0] rd_addr;
  logic [63:0] meta_rd, meta_wdata;
  logic [7:0]  mem_rd_q;

  logic [7:0]  buf_mem  [DEPTH];
  logic [63:0] meta_mem [MDEPTH];

  // Writer only touches space beyond the committed pointer, reader only below it
  assign buf_full   = (wp_q - rp_q) == {1'b1, {AW{1'b0}}};
  assign meta_full  = (meta_wp_q - meta_rp_q) == {1'b1, {MW{1'b0}}};
  assign meta_empty = meta_wp_q == meta_rp_q;
  assign meta_rd    = meta_mem[meta_rp_q[MW-1:0]];
  assign meta_wdata = {srcip_q, srcport_q, udplen_q - 16'd8};
  assign udplen_full = {udplen_q[15:8], rx_data};

  always_comb begin
    p_state_d  = p_state_q;
    idx_d      = idx_q;
    srcip_d    = srcip_q;
    srcport_d  = srcport_q;
    udplen_d   = udplen_q;
    pay_rem_d  = pay_rem_q;
    wp_d       = wp_q;
    wp_start_d = wp_start_q;
    wc_d       = wc_q;
    wr_en      = 1'b0;
    commit     = 1'b0;
    discard    = 1'b0;
    ip_bad     = rx_ethertype != 16'h0800;
    udp_bad    = 1'b0;
    case (idx_q)
      5'd0:    ip_bad = ip_bad || (rx_data != 8'h45);
      5'd9:    ip_bad = ip_bad || (rx_data != 8'd17);
      5'd16:   ip_bad = ip_bad || (rx_data != myip[31:24]);
      5'd17:   ip_bad = ip_bad || (rx_data != myip[23:16]);
      5'd18:   ip_bad = ip_bad || (rx_data != myip[15:8]);
      5'd19:   ip_bad = ip_bad || (rx_data != myip[7:0]);
      default: ;
    endcase
    if (rx_newframehead) begin
      discard    = p_state_q != P_IDLE;
      p_state_d  = P_IP;
      idx_d      = 5'd0;
      wp_start_d = wc_q;
      wp_d       = wc_q;
    end else if (rx_frameend && p_state_q != P_IDLE) begin
      p_state_d = P_IDLE;
      if (p_state_q == P_WAIT && !rx_err && !meta_full) begin
        commit = 1'b1;
        wc_d   = wp_q;
      end else begin
        discard = 1'b1;
      end
    end else if (rx_dven) begin
      case (p_state_q)
        P_IP: begin
          idx_d = idx_q + 5'd1;
          if (idx_q >= 5'd12 && idx_q <= 5'd15) srcip_d = {srcip_q[23:0], rx_data};
          if (ip_bad) p_state_d = P_DROP;
          else if (idx_q == 5'd19) begin
            p_state_d = P_UDP;
            idx_d     = 5'd0;
          end
        end
        P_UDP: begin
          idx_d = idx_q + 5'd1;
          case (idx_q)
            5'd0, 5'd1: srcport_d = {srcport_q[7:0], rx_data};
            5'd2: udp_bad = rx_data != UDPPORT[15:8];
            5'd3: udp_bad = rx_data != UDPPORT[7:0];
            5'd4: udplen_d = {rx_data, udplen_q[7:0]};
            5'd5: begin
              udplen_d = udplen_full;
              udp_bad  = (udplen_full < 16'd8) || ({1'b0, udplen_full} > MAX_UDPLEN);
            end
            5'd7: begin
              idx_d     = 5'd0;
              pay_rem_d = udplen_q - 16'd8;
              p_state_d = (udplen_q == 16'd8) ? P_WAIT : P_PAY;
            end
            default: ;
          endcase
          if (udp_bad) p_state_d = P_DROP;
        end
        P_PAY: begin
          if (buf_full) begin
            p_state_d = P_DROP;
            wp_d      = wp_start_q;
          end else begin
            wr_en     = 1'b1;
            wp_d      = wp_q + PONE;
            pay_rem_d = pay_rem_q - 16'd1;
            if (pay_rem_q == 16'd1) p_state_d = P_WAIT;
          end
        end
        default: ;
      endcase
    end
    // Any discarded frame gives back its speculative space
    if (discard) wp_d = wp_start_q;
  end

  always_comb begin
    r_state_d     = r_state_q;
    rp_d          = rp_q;
    r_rem_d       = r_rem_q;
    out_srcip_d   = out_srcip_q;
    out_srcport_d = out_srcport_q;
    out_len_d     = out_len_q;
    meta_pop      = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = rp_q[AW-1:0];
    case (r_state_q)
      R_IDLE: if (!meta_empty) r_state_d = R_LOAD;
      R_LOAD: begin
        meta_pop = 1'b1;
        {out_srcip_d, out_srcport_d, out_len_d} = meta_rd;
        r_rem_d = meta_rd[15:0];
        if (meta_rd[15:0] == 16'd0) r_state_d = R_IDLE;
        else begin
          rd_en     = 1'b1;
          r_state_d = R_STREAM;
        end
      end
      R_STREAM: begin
        if (out_ready) begin
          rp_d = rp_q + PONE;
          if (r_rem_q == 16'd1) r_state_d = R_IDLE;
          else begin
            r_rem_d = r_rem_q - 16'd1;
            rd_en   = 1'b1;
            rd_addr = rp_d[AW-1:0];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign meta_wp_d = commit ? meta_wp_q + MONE : meta_wp_q;
  assign meta_rp_d = meta_pop ? meta_rp_q + MONE : meta_rp_q;

  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wp_q[AW-1:0]] <= rx_data;
    if (rd_en) mem_rd_q <= buf_mem[rd_addr];
    if (commit) meta_mem[meta_wp_q[MW-1:0]] <= meta_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_state_q     <= P_IDLE;
      r_state_q     <= R_IDLE;
      idx_q         <= '0;
      srcip_q       <= '0;
      srcport_q     <= '0;
      udplen_q      <= '0;
      pay_rem_q     <= '0;
      wp_q          <= '0;
      wp_start_q    <= '0;
      wc_q          <= '0;
      rp_q          <= '0;
      meta_wp_q     <= '0;
      meta_rp_q     <= '0;
      r_rem_q       <= '0;
      out_srcip_q   <= '0;
      out_srcport_q <= '0;
      out_len_q     <= '0;
    end else begin
      p_state_q     <= p_state_d;
      r_state_q     <= r_state_d;
      idx_q         <= idx_d;
      srcip_q       <= srcip_d;
      srcport_q     <= srcport_d;
      udplen_q      <= udplen_d;
      pay_rem_q     <= pay_rem_d;
      wp_q          <= wp_d;
      wp_start_q    <= wp_start_d;
      wc_q          <= wc_d;
      rp_q          <= rp_d;
      meta_wp_q     <= meta_wp_d;
      meta_rp_q     <= meta_rp_d;
      r_rem_q       <= r_rem_d;
      out_srcip_q   <= out_srcip_d;
      out_srcport_q <= out_srcport_d;
      out_len_q     <= out_len_d;
    end
  end

  assign out_valid   = r_state_q == R_STREAM;
  assign out_last    = out_valid && (r_rem_q == 16'd1);
  assign out_data    = out_valid ? mem_rd_q : 8'd0;
  assign out_srcip   = out_srcip_q;
  assign out_srcport = out_srcport_q;
  assign out_len     = out_len_q;

`ifdef ETH_UDP_RX_STATS_EN
  logic [15:0] cnt_ok_q, cnt_ok_d, cnt_drop_q, cnt_drop_d;
  assign cnt_ok_d   = cnt_ok_q + {15'd0, commit};
  assign cnt_drop_d = cnt_drop_q + {15'd0, discard};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_ok_q   <= '0;
      cnt_drop_q <= '0;
    end else begin
      cnt_ok_q   <= cnt_ok_d;
      cnt_drop_q <= cnt_drop_d;
    end
  end
  assign cnt_ok   = cnt_ok_q;
  assign cnt_drop = cnt_drop_q;
`else
  assign cnt_ok   = 16'd0;
  assign cnt_drop = 16'd0;
`endif
endmodule

// File: tb/tb_eth_udp_rx.sv
// Directed bench for eth_udp_rx: frames are built byte by byte, accepted payload is queued
// on a scoreboard and checked against the output stream as it is handshaken.
module tb_eth_udp_rx;
  localparam logic [31:0] MYIP = 32'h0A000002;
  localparam logic [15:0] PORT = 16'd50000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_dven = 1'b0, rx_newframehead = 1'b0, rx_frameend = 1'b0, rx_err = 1'b0;
  logic [15:0] rx_ethertype = 16'h0800;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_valid, out_last;
  logic [31:0] out_srcip;
  logic [15:0] out_srcport, out_len, cnt_ok, cnt_drop;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [31:0] ip;
    logic [15:0] port;
    logic [15:0] len;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, failures = 0;
  int   exp_ok = 0, exp_drop = 0;

  eth_udp_rx dut (
    .clk(clk), .reset_n(reset_n), .myip(MYIP), .rx_data(rx_data), .rx_dven(rx_dven),
    .rx_newframehead(rx_newframehead), .rx_ethertype(rx_ethertype), .rx_frameend(rx_frameend),
    .rx_err(rx_err), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .out_srcip(out_srcip), .out_srcport(out_srcport), .out_len(out_len),
    .cnt_ok(cnt_ok), .cnt_drop(cnt_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] stat(input int n);
`ifdef ETH_UDP_RX_STATS_EN
    return 16'(n);
`else
    return 16'(n & 0);
`endif
  endfunction

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(mon_e.data));
        chk("out_last", 64'(out_last), 64'(mon_e.last));
        chk("out_srcip", 64'(out_srcip), 64'(mon_e.ip));
        chk("out_srcport", 64'(out_srcport), 64'(mon_e.port));
        chk("out_len", 64'(out_len), 64'(mon_e.len));
        $display("out byte=%02h last=%0b src=%08h:%0d len=%0d", out_data, out_last,
                 out_srcip, out_srcport, out_len);
      end
    end
  end

  // cut>=0 stops after that many data bytes; noend suppresses the frame-end strobe
  task automatic send_frame(input logic [31:0] dip, input logic [15:0] dport, input logic [7:0] proto,
                            input logic [15:0] ulen, input int npay, input logic [15:0] etype,
                            input logic err, input bit good, input int cut, input bit noend);
    logic [7:0]  b[$];
    logic [31:0] sip;
    logic [15:0] sport, tot;
    logic [7:0]  d;
    exp_t        e;
    sip   = $urandom;
    sport = 16'($urandom);
    tot   = ulen + 16'd20;
    b = {8'h45, 8'h00, tot[15:8], tot[7:0], 8'h00, 8'h00, 8'h40, 8'h00, 8'd64, proto, 8'h00, 8'h00,
         sip[31:24], sip[23:16], sip[15:8], sip[7:0], dip[31:24], dip[23:16], dip[15:8], dip[7:0],
         sport[15:8], sport[7:0], dport[15:8], dport[7:0], ulen[15:8], ulen[7:0], 8'h00, 8'h00};
    for (int i = 0; i < npay; i++) begin
      d = 8'($urandom);
      b.push_back(d);
      if (good) begin
        e.data = d; e.last = (i == npay - 1); e.ip = sip; e.port = sport; e.len = 16'(npay);
        exp_q.push_back(e);
      end
    end
    while (b.size() < 46) b.push_back(8'h00);
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    $display("frame dip=%08h dport=%0d proto=%0d udplen=%0d etype=%04h err=%0b accept=%0b",
             dip, dport, proto, ulen, etype, err, good);
    @(posedge clk); #1;
    rx_ethertype = etype;
    rx_newframehead = 1'b1;
    @(posedge clk); #1;
    rx_newframehead = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      if (cut >= 0 && i == cut) break;
      rx_dven = 1'b1;
      rx_data = b[i];
      @(posedge clk); #1;
    end
    rx_dven = 1'b0;
    if (!noend) begin
      rx_frameend = 1'b1;
      rx_err = err;
      @(posedge clk); #1;
      rx_frameend = 1'b0;
      rx_err = 1'b0;
      if (good) exp_ok++; else exp_drop++;
    end
  endtask

  task automatic drain(input string tag, input bit rand_ready);
    int n = 0;
    while (exp_q.size() != 0 && n < 8000) begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    chk(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_len", 64'(out_len), 64'd0);
    chk("rst_cnt_ok", 64'(cnt_ok), 64'd0);
    chk("rst_cnt_drop", 64'(cnt_drop), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    send_frame(MYIP, PORT, 8'd17, 16'd12, 4, 16'h0800, 1'b0, 1'b1, -1, 1'b0);
    drain("basic", 1'b0);
    chk("basic_cnt_ok", 64'(cnt_ok), 64'(stat(exp_ok)));

    send_frame(MYIP, PORT, 8'd17, 16'd12, 4, 16'h0800, 1'b1, 1'b0, -1, 1'b0);
    drain("crc_err", 1'b0);
    chk("crc_err_cnt_drop", 64'(cnt_drop), 64'(stat(exp_drop)));

    send_frame(32'h0A000003, PORT, 8'd17, 16'd12, 4, 16'h0800, 1'b0, 1'b0, -1, 1'b0);
    send_frame(MYIP, PORT + 16'd1, 8'd17, 16'd12, 4, 16'h0800, 1'b0, 1'b0, -1, 1'b0);
    send_frame(MYIP, PORT, 8'd6, 16'd12, 4, 16'h0800, 1'b0, 1'b0, -1, 1'b0);
    drain("bad_hdr", 1'b0);
    chk("bad_hdr_cnt_drop", 64'(cnt_drop), 64'(stat(exp_drop)));
    send_frame(MYIP, PORT, 8'd17, 16'd12, 4, 16'h86DD, 1'b0, 1'b0, -1, 1'b0);
    send_frame(MYIP, PORT, 8'd17, 16'd7, 4, 16'h0800, 1'b0, 1'b0, -1, 1'b0);
    send_frame(MYIP, PORT, 8'd17, 16'd2056, 10, 16'h0800, 1'b0, 1'b0, -1, 1'b0);
    send_frame(MYIP, PORT, 8'd17, 16'd12, 4, 16'h0800, 1'b0, 1'b0, 10, 1'b0);
    drain("bad_len_runt", 1'b0);
    chk("bad_len_runt_cnt_drop", 64'(cnt_drop), 64'(stat(exp_drop)));

    send_frame(MYIP, PORT, 8'd17, 16'd9, 1, 16'h0800, 1'b0, 1'b1, -1, 1'b0);
    drain("min_frame", 1'b0);
    send_frame(MYIP, PORT, 8'd17, 16'd8, 0, 16'h0800, 1'b0, 1'b1, -1, 1'b0);
    send_frame(MYIP, PORT, 8'd17, 16'd15, 7, 16'h0800, 1'b0, 1'b1, -1, 1'b0);
    drain("zero_len", 1'b0);
    chk("zero_len_cnt_ok", 64'(cnt_ok), 64'(stat(exp_ok)));

    // One datagram sits stalled in the reader, four fill the metadata FIFO, the sixth has no slot
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      send_frame(MYIP, PORT, 8'd17, 16'd108, 100, 16'h0800, 1'b0, 1'b1, -1, 1'b0);
    send_frame(MYIP, PORT, 8'd17, 16'd108, 100, 16'h0800, 1'b0, 1'b0, -1, 1'b0);
    @(negedge clk);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_data", 64'(out_data), 64'(exp_q[0].data));
    repeat (3) @(negedge clk);
    chk("stall_hold", 64'(out_data), 64'(exp_q[0].data));
    chk("stall_last", 64'(out_last), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("backlog", 1'b0);
    chk("backlog_cnt_ok", 64'(cnt_ok), 64'(stat(exp_ok)));
    chk("backlog_cnt_drop", 64'(cnt_drop), 64'(stat(exp_drop)));

    send_frame(MYIP, PORT, 8'd17, 16'd2055, 2047, 16'h0800, 1'b0, 1'b1, -1, 1'b0);
    drain("max_len", 1'b1);

    send_frame(MYIP, PORT, 8'd17, 16'd50, 42, 16'h0800, 1'b0, 1'b0, 38, 1'b1);
    reset_n = 1'b0;
    exp_ok = 0;
    exp_drop = 0;
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_cnt_ok", 64'(cnt_ok), 64'd0);
    chk("rst2_cnt_drop", 64'(cnt_drop), 64'd0);
    send_frame(MYIP, PORT, 8'd17, 16'd20, 12, 16'h0800, 1'b0, 1'b1, -1, 1'b0);
    drain("after_rst", 1'b0);
    chk("after_rst_cnt_ok", 64'(cnt_ok), 64'(stat(exp_ok)));
    chk("after_rst_cnt_drop", 64'(cnt_drop), 64'(stat(exp_drop)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
